mudv_ctl: RTL and testbench

- Multiply/divide sequencer for the pipelined MIPS core. Sits in the E stage and owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and holds a busy interval of fixed latency.
- Exports `occupied` to the D-stage stall logic. Any M/D trigger, move-to or move-from instruction in D stalls while `occupied`=1.

---
 rtl/mudv_ctl.sv | 144 ++++++++++++++
 tb/tb_mudv_ctl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mudv_ctl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, computes the result at
// issue time and holds it back for a fixed busy window before committing it.
module mudv_ctl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hi,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  count_r, count_s;
  logic        busy_r, busy_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;
  logic [31:0] ph_r, ph_s, pl_r, pl_s;
  logic [63:0] res_s;

  // Divide by zero returns the current {hi, lo} so the commit leaves them untouched.
  function automatic logic [63:0] md_result(input logic [2:0] f_op, input logic [31:0] f_a,
                                            input logic [31:0] f_b, input logic [31:0] f_hi,
                                            input logic [31:0] f_lo);
    logic [63:0]        r;
    logic signed [31:0] q;
    logic signed [31:0] m;
    r = {f_hi, f_lo};
    q = 32'sd0;
    m = 32'sd0;
    case (f_op)
      3'd0: r = {{32{f_a[31]}}, f_a} * {{32{f_b[31]}}, f_b};
      3'd1: r = {32'd0, f_a} * {32'd0, f_b};
      3'd2: begin
        if (f_b == 32'd0) begin
          r = {f_hi, f_lo};
        end else if ((f_a == 32'h8000_0000) && (f_b == 32'hFFFF_FFFF)) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          q = $signed(f_a) / $signed(f_b);
          m = $signed(f_a) % $signed(f_b);
          r = {m, q};
        end
      end
      3'd3: begin
        if (f_b == 32'd0) begin
          r = {f_hi, f_lo};
        end else begin
          r = {f_a % f_b, f_a / f_b};
        end
      end
      default: r = {f_hi, f_lo};
    endcase
    return r;
  endfunction

  assign res_s    = md_result(op, a, b, hi_r, lo_r);
  assign busy     = busy_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign occupied = start | busy_r;
  assign rdata    = rd_hi ? hi_r : lo_r;

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    busy_s  = busy_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    ph_s    = ph_r;
    pl_s    = pl_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              ph_s    = res_s[63:32];
              pl_s    = res_s[31:0];
              count_s = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              busy_s  = 1'b1;
              state_s = ST_BUSY;
            end
            3'd4:    hi_s = a;
            3'd5:    lo_s = a;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (count_r == 4'd1) begin
          hi_s    = ph_r;
          lo_s    = pl_r;
          count_s = 4'd0;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          count_s = count_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = 4'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= 4'd0;
      busy_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      ph_r    <= 32'd0;
      pl_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      busy_r  <= busy_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      ph_r    <= ph_s;
      pl_r    <= pl_s;
    end
  end

endmodule

// File: tb/tb_mudv_ctl.sv
// Self-checking bench for mudv_ctl: directed scenarios plus random operations
// compared against an arithmetic model that tracks busy windows by cycle number.
module tb_mudv_ctl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        rd_hi = 1'b0;
  logic        busy, occupied;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int failures = 0;

  // model state: edges seen, edge at which busy ends, pending result
  int          cyc = 0;
  int          done_at = 0;
  logic        m_dz = 1'b0;
  logic [63:0] m_pend = 64'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mudv_ctl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd_hi(rd_hi),
    .busy(busy), .occupied(occupied), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] av,
                                             input logic [31:0] bv);
    longint      sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: return (bv == 32'd0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return (bv == 32'd0) ? 64'd0 : {av % bv, av / bv};
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] av,
                            input logic [31:0] bv);
    bit was_busy;
    was_busy = (cyc < done_at);
    cyc++;
    if (was_busy) begin
      if (cyc == done_at && !m_dz) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
    end else if (s) begin
      if (o <= 3'd3) begin
        m_pend  = ref_result(o, av, bv);
        m_dz    = (o >= 3'd2) && (bv == 32'd0);
        done_at = cyc + ((o >= 3'd2) ? DIV_N : MULT_N);
      end else if (o == 3'd4) begin
        m_hi = av;
      end else if (o == 3'd5) begin
        m_lo = av;
      end
    end
  endtask

  // one clock: drive, check combinational outputs, clock, check registered outputs
  task automatic cycle(input logic s, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic rh);
    start = s; op = o; a = av; b = bv; rd_hi = rh;
    #1;
    chk("occupied", {31'd0, occupied}, {31'd0, s | (cyc < done_at)});
    chk("rdata", rdata, rh ? m_hi : m_lo);
    @(posedge clk);
    model_edge(s, o, av, bv);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, cyc < done_at});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd7, 32'd0, 32'd0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [31:0] ra, rb;
    // reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_occupied", {31'd0, occupied}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // MULT -2 * 3
    cycle(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MULT_N);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    cycle(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle(MULT_N);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // DIV -7/2 then DIVU by zero
    cycle(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DIV_N);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    cycle(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(DIV_N);
    chk("divz_lo", lo, 32'hFFFF_FFFD);
    chk("divz_hi", hi, 32'hFFFF_FFFF);

    // DIV overflow corner
    cycle(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DIV_N);
    chk("divov_lo", lo, 32'h8000_0000);
    chk("divov_hi", hi, 32'h0000_0000);

    // MTHI then MTLO back to back
    cycle(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
    cycle(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b1);
    cycle(1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
    chk("mt_rdata_hi", rdata, 32'h1234_5678);
    cycle(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    chk("mt_rdata_lo", rdata, 32'h9ABC_DEF0);

    // start while busy is ignored
    cycle(1'b1, 3'd0, 32'd6, 32'd7, 1'b0);
    idle(1);
    cycle(1'b1, 3'd5, 32'h0000_DEAD, 32'd0, 1'b0);
    idle(MULT_N - 2);
    chk("restart_lo", lo, 32'd42);
    chk("restart_busy", {31'd0, busy}, 32'd0);

    // async reset in busy cycle 3 of a DIV
    cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle(2);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; done_at = cyc;
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1'b1, 3'd4, 32'hCAFE_F00D, 32'd0, 1'b1);
    chk("post_rst_hi", hi, 32'hCAFE_F00D);

    // random operations, including starts while busy
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb,
            1'($urandom_range(0, 1)));
    end
    idle(DIV_N + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
